// File: rtl/jtkiwi_pkg.sv
// rtl/jtkiwi_pkg.sv - shared types and constants for the SETA tile-map scanner
// Contents: scanner state enum, tile/map geometry, attr flip bit positions,
// and the VRAM word-address packing helper.
package jtkiwi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RDCODE,
    RDATTR,
    ISSUE,
    HOLD
  } scan_state_t;

  localparam int TILE_W     = 16;
  localparam int MAP_COLS   = 32;
  localparam int MAP_ROWS   = 16;
  localparam int ATTR_HFLIP = 15;
  localparam int ATTR_VFLIP = 14;

  localparam int COL_W = $clog2(MAP_COLS);
  localparam int ROW_W = $clog2(MAP_ROWS);

  // Tile-map VRAM word address: {row, col, sel}, sel=0 code, sel=1 attr
  function automatic logic [9:0] tile_addr(input logic [ROW_W-1:0] row,
                                           input logic [COL_W-1:0] col,
                                           input logic             sel);
    return {row, col, sel};
  endfunction

endpackage

// File: rtl/jtkiwi_scan_fetch.sv
// rtl/jtkiwi_scan_fetch.sv - VRAM read request and staging registers
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   req, req_addr         start a read at req_addr (wins over abort)
//   abort                 drop an outstanding read
//   vram_ok, vram_data    read handshake from VRAM
//   vram_cs, vram_addr    read request to VRAM; address frozen while cs=1
//   rd_ok                 the outstanding read completes this cycle
//   code_stage/attr_stage latest code/attr words, routed by address bit 0
module jtkiwi_scan_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [9:0]  req_addr,
  input  logic        abort,
  input  logic        vram_ok,
  input  logic [15:0] vram_data,
  output logic        vram_cs,
  output logic [9:0]  vram_addr,
  output logic        rd_ok,
  output logic [15:0] code_stage,
  output logic [15:0] attr_stage
);

  // vram_ok outside an active request is ignored
  assign rd_ok = vram_cs & vram_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vram_cs    <= 1'b0;
      vram_addr  <= 10'd0;
      code_stage <= 16'd0;
      attr_stage <= 16'd0;
    end else begin
      if (rd_ok) begin
        if (vram_addr[0]) attr_stage <= vram_data;
        else              code_stage <= vram_data;
        vram_cs <= 1'b0;
      end
      if (abort) vram_cs <= 1'b0;
      if (req) begin
        vram_cs   <= 1'b1;
        vram_addr <= req_addr;
      end
    end
  end

endmodule

// File: rtl/jtkiwi_scan.sv
// rtl/jtkiwi_scan.sv - tile-map scanner issuing per-column draw commands
// Optional feature macro: JTKIWI_FLIP_EN (screen flip; flip is ignored without it)
// Ports:
//   clk, rst                pixel clock, asynchronous active-low reset
//   hs                      line-start strobe, rising edge starts a line
//   vrender, scrx, scry     next line number, X/Y scroll
//   flip                    screen flip
//   vram_addr/cs/ok/data    tile-map VRAM read port
//   draw, busy              draw command / drawer busy handshake
//   code, attr, xpos, ysub  tile parameters, stable while the drawer is busy
//   done                    all columns of the current line issued
module jtkiwi_scan
  import jtkiwi_pkg::*;
#(
  parameter int NCOLS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic [7:0]  vrender,
  input  logic [8:0]  scrx,
  input  logic [7:0]  scry,
  input  logic        flip,
  output logic [9:0]  vram_addr,
  output logic        vram_cs,
  input  logic        vram_ok,
  input  logic [15:0] vram_data,
  output logic        draw,
  input  logic        busy,
  output logic [15:0] code,
  output logic [15:0] attr,
  output logic [8:0]  xpos,
  output logic [3:0]  ysub,
  output logic        done
);

  scan_state_t st;
  logic        hs_q;
  logic [3:0]  row;
  logic [4:0]  col0;
  logic [3:0]  fine;
  logic [3:0]  ysub_l;
  logic [4:0]  cnt;
  logic        hold_first;

  logic        hs_rise;
  logic [7:0]  ypos_n;
  logic [4:0]  col_cur;
  logic [8:0]  xbase;
  logic [8:0]  xnext;
  logic [15:0] attr_mask;
  logic        flip_eff;

  logic        req;
  logic        abort;
  logic [9:0]  req_addr;
  logic        rd_ok;
  logic [15:0] code_stage;
  logic [15:0] attr_stage;

`ifdef JTKIWI_FLIP_EN
  logic flip_l;
  assign flip_eff = flip_l;
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign flip_eff    = 1'b0;
`endif

  assign hs_rise = hs & ~hs_q;
  assign col_cur = col0 + cnt;
  assign xbase   = 9'(cnt) * 9'(TILE_W) - {5'd0, fine};
  assign xnext   = flip_eff ? 9'd496 - xbase : xbase;
  assign attr_mask = flip_eff ? (16'd1 << ATTR_HFLIP) | (16'd1 << ATTR_VFLIP) : 16'd0;

  always_comb begin
    ypos_n = vrender + scry;
`ifdef JTKIWI_FLIP_EN
    if (flip) ypos_n = ~ypos_n;
`endif
  end

  // Read requests. From IDLE the first code read starts on the hs edge itself;
  // a mid-scan hs first drops the outstanding read so the address never moves
  // under an active cs. Between two reads cs is always low for one cycle.
  always_comb begin
    req      = 1'b0;
    abort    = 1'b0;
    req_addr = tile_addr(row, col_cur, 1'b0);
    if (hs_rise) begin
      if (st == IDLE) begin
        req      = 1'b1;
        req_addr = tile_addr(ypos_n[7:4], scrx[8:4], 1'b0);
      end else begin
        abort = 1'b1;
      end
    end else begin
      case (st)
        RDCODE: req = !vram_cs;
        RDATTR: begin
          req      = !vram_cs;
          req_addr = tile_addr(row, col_cur, 1'b1);
        end
        default: req = 1'b0;
      endcase
    end
  end

  jtkiwi_scan_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .abort      (abort),
    .vram_ok    (vram_ok),
    .vram_data  (vram_data),
    .vram_cs    (vram_cs),
    .vram_addr  (vram_addr),
    .rd_ok      (rd_ok),
    .code_stage (code_stage),
    .attr_stage (attr_stage)
  );

  // Drawer-facing outputs change only in ISSUE, and ISSUE only proceeds with
  // busy low, so a restart never disturbs a tile being drawn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      hs_q       <= 1'b0;
      row        <= 4'd0;
      col0       <= 5'd0;
      fine       <= 4'd0;
      ysub_l     <= 4'd0;
      cnt        <= 5'd0;
      hold_first <= 1'b0;
      draw       <= 1'b0;
      code       <= 16'd0;
      attr       <= 16'd0;
      xpos       <= 9'd0;
      ysub       <= 4'd0;
      done       <= 1'b0;
`ifdef JTKIWI_FLIP_EN
      flip_l     <= 1'b0;
`endif
    end else begin
      hs_q <= hs;
      draw <= 1'b0;
      if (hs_rise) begin
        row        <= ypos_n[7:4];
        ysub_l     <= ypos_n[3:0];
        col0       <= scrx[8:4];
        fine       <= scrx[3:0];
        cnt        <= 5'd0;
        done       <= 1'b0;
        hold_first <= 1'b0;
        st         <= RDCODE;
`ifdef JTKIWI_FLIP_EN
        flip_l     <= flip;
`endif
      end else begin
        case (st)
          IDLE: st <= IDLE;
          RDCODE: if (rd_ok) st <= RDATTR;
          RDATTR: if (rd_ok) st <= ISSUE;
          ISSUE: if (!busy) begin
            code       <= code_stage;
            attr       <= attr_stage ^ attr_mask;
            xpos       <= xnext;
            ysub       <= ysub_l;
            draw       <= 1'b1;
            hold_first <= 1'b1;
            st         <= HOLD;
          end
          HOLD: begin
            // busy is not yet valid on the cycle right after draw
            if (hold_first) begin
              hold_first <= 1'b0;
            end else if (!busy) begin
              cnt <= cnt + 5'd1;
              if (cnt == 5'(NCOLS - 1)) begin
                done <= 1'b1;
                st   <= IDLE;
              end else begin
                st <= RDCODE;
              end
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtkiwi_scan.sv
// tb/tb_jtkiwi_scan.sv - randomized self-checking bench for jtkiwi_scan
module tb_jtkiwi_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hs = 1'b0;
  logic [7:0]  vrender = 8'd0;
  logic [8:0]  scrx = 9'd0;
  logic [7:0]  scry = 8'd0;
  logic        flip = 1'b0;
  logic [9:0]  vram_addr;
  logic        vram_cs;
  logic        vram_ok = 1'b0;
  logic [15:0] vram_data = 16'd0;
  logic        draw;
  logic        busy = 1'b0;
  logic [15:0] code;
  logic [15:0] attr;
  logic [8:0]  xpos;
  logic [3:0]  ysub;
  logic        done;

  jtkiwi_scan #(.NCOLS(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs),
    .vrender   (vrender),
    .scrx      (scrx),
    .scry      (scry),
    .flip      (flip),
    .vram_addr (vram_addr),
    .vram_cs   (vram_cs),
    .vram_ok   (vram_ok),
    .vram_data (vram_data),
    .draw      (draw),
    .busy      (busy),
    .code      (code),
    .attr      (attr),
    .xpos      (xpos),
    .ysub      (ysub),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [15:0] code;
    logic [15:0] attr;
    logic [8:0]  xpos;
    logic [3:0]  ysub;
  } exp_t;

  logic [15:0] mem [1024];
  exp_t        expq[$];
  logic [9:0]  rd_log[$];
  int          ndraw = 0;
  int          busy_len = 0;

  // Reference: what the 17 draws of a line must carry
  task automatic plan_line(input int vr, input int sx, input int sy, input bit fl);
    int   ypos, row, col, x;
    exp_t e;
    bit   eff;
`ifdef JTKIWI_FLIP_EN
    eff = fl;
`else
    eff = 1'b0;
`endif
    ypos = (vr + sy) % 256;
    if (eff) ypos = 255 - ypos;
    row = ypos / 16;
    expq.delete();
    for (int c = 0; c < 17; c++) begin
      col = ((sx / 16) + c) % 32;
      e.code = mem[row * 64 + col * 2];
      e.attr = mem[row * 64 + col * 2 + 1];
      if (eff) e.attr = e.attr ^ 16'hC000;
      x = (c * 16 - (sx % 16) + 512) % 512;
      if (eff) x = (496 - x + 512) % 512;
      e.xpos = 9'(x);
      e.ysub = 4'(ypos % 16);
      expq.push_back(e);
    end
  endtask

  // VRAM model: random latency, stray vram_ok while idle, address stability
  int         rd_wait = -1;
  logic [9:0] rd_addr_q = 10'd0;
  always @(negedge clk) begin
    if (!vram_cs) begin
      rd_wait   = -1;
      vram_ok   = ($urandom_range(0, 3) == 0);
      vram_data = 16'($urandom);
    end else begin
      if (rd_wait < 0) begin
        rd_wait   = $urandom_range(0, 3);
        rd_addr_q = vram_addr;
        rd_log.push_back(vram_addr);
      end else begin
        check("addr_stable", vram_addr, rd_addr_q);
      end
      if (rd_wait == 0) begin
        vram_ok   = 1'b1;
        vram_data = mem[vram_addr];
      end else begin
        vram_ok   = 1'b0;
        vram_data = 16'($urandom);
        rd_wait--;
      end
    end
  end

  // Drawer model: busy from the cycle after draw for bcnt cycles
  int   bcnt = 0;
  logic prev_draw = 1'b0;
  exp_t de;
  exp_t snap;
  always @(negedge clk) begin
    if (!rst) begin
      busy      = 1'b0;
      bcnt      = 0;
      prev_draw = 1'b0;
    end else begin
      if (draw) begin
        check("draw_while_busy", busy, 0);
        check("draw_back_to_back", prev_draw, 0);
        ndraw++;
        if (expq.size() == 0) begin
          check("draw_unexpected", expq.size(), 1);
        end else begin
          de = expq.pop_front();
          check("code", code, de.code);
          check("attr", attr, de.attr);
          check("xpos", xpos, de.xpos);
          check("ysub", ysub, de.ysub);
        end
        snap.code = code;
        snap.attr = attr;
        snap.xpos = xpos;
        snap.ysub = ysub;
        busy = 1'b1;
        bcnt = (busy_len != 0) ? busy_len : $urandom_range(1, 25);
      end else if (busy) begin
        check("hold_code", code, snap.code);
        check("hold_attr", attr, snap.attr);
        check("hold_xpos", xpos, snap.xpos);
        check("hold_ysub", ysub, snap.ysub);
        if (bcnt <= 1) busy = 1'b0;
        else bcnt--;
      end
      prev_draw = draw;
    end
  end

  int base;

  task automatic start_line(input int vr, input int sx, input int sy, input bit fl);
    @(negedge clk);
    vrender = 8'(vr);
    scrx    = 9'(sx);
    scry    = 8'(sy);
    flip    = fl;
    plan_line(vr, sx, sy, fl);
    rd_log.delete();
    base = ndraw;
    hs   = 1'b1;
    @(negedge clk);
    hs   = 1'b0;
  endtask

  task automatic finish_line(input string tag);
    for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_ndraw"}, ndraw - base, 17);
    check({tag, "_left"}, expq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("rst_draw", draw, 0);
    check("rst_cs", vram_cs, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_code", code, 0);
    check("rst_attr", attr, 0);
    check("rst_xpos", xpos, 0);
    check("rst_ysub", ysub, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Straight line, no scroll
    start_line(8'h23, 0, 0, 0);
    finish_line("l23");
    check("l23_rd0", rd_log[0], 10'h080);
    check("l23_rd1", rd_log[1], 10'h081);
    check("l23_rd2", rd_log[2], 10'h082);

    // Column wrap: col0=31 then 0, first xpos 0x1FB
    start_line(8'h10, 9'h1F5, 8'h05, 0);
    finish_line("wrap");
    check("wrap_rd0", rd_log[0], 10'h07E);
    check("wrap_rd2", rd_log[2], 10'h040);

    // Long drawer busy
    busy_len = 20;
    start_line($urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 255), 0);
    finish_line("busy20");
    busy_len = 0;

    // Random lines, random flip input
    for (int n = 0; n < 6; n++) begin
      start_line($urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)));
      finish_line("rand");
    end

`ifdef JTKIWI_FLIP_EN
    start_line(8'h37, 0, 8'h02, 1);
    finish_line("flip");
`endif

    // hs mid-scan while the drawer is busy on column 5
    busy_len = 20;
    start_line(8'h44, 9'h023, 8'h00, 0);
    for (int i = 0; i < 3000 && !((ndraw - base) >= 6 && busy); i++) @(negedge clk);
    check("mid_reached", ((ndraw - base) >= 6) && busy, 1);
    vrender = 8'h9A;
    plan_line(8'h9A, 9'h023, 8'h00, 0);
    base = ndraw;
    hs   = 1'b1;
    @(negedge clk);
    hs   = 1'b0;
    finish_line("mid");
    busy_len = 0;

    // Reset mid-scan
    start_line(8'h61, 9'h10C, 8'h33, 0);
    for (int i = 0; i < 3000 && (ndraw - base) < 3; i++) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mrst_draw", draw, 0);
      check("mrst_cs", vram_cs, 0);
    end
    check("mrst_addr", vram_addr, 0);
    check("mrst_code", code, 0);
    check("mrst_attr", attr, 0);
    check("mrst_xpos", xpos, 0);
    check("mrst_ysub", ysub, 0);
    check("mrst_done", done, 0);
    rst = 1'b1;
    expq.delete();
    base = ndraw;
    repeat (40) @(negedge clk);
    check("post_rst_ndraw", ndraw - base, 0);
    check("post_rst_cs", vram_cs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
